// File: rtl/score_logger_pkg.sv
// Shared constants, state type and score helper for the game-over score logger.
package score_log_pkg;

    localparam int DEPTH     = 32;   // score slots, power of two
    localparam int ADDR_W    = 5;    // log2(DEPTH)
    localparam int SCORE_W   = 10;   // score / memory data width
    localparam int MAX_SCORE = 999;  // score saturation value

    typedef enum logic [1:0] {
        CLEAR,
        PLAY,
        WRITE,
        HOLD
    } log_state_t;

    // Increment a score, sticking at MAX_SCORE.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s >= SCORE_W'(MAX_SCORE)) begin
            return SCORE_W'(MAX_SCORE);
        end
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/score_logger_if.sv
// Synchronous write port of the score memory (address/data/wren).
interface score_logger_if;
    import score_log_pkg::*;

    logic [ADDR_W-1:0]  address;
    logic [SCORE_W-1:0] data;
    logic               wren;

    modport master (output address, output data, output wren);
    modport slave  (input  address, input  data, input  wren);

endinterface

// File: rtl/score_logger_edge.sv
// Rising-edge detector; the previous value resets to 1 so a level already
// high when reset releases does not look like a fresh edge.
module rising_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic prev_d;
    logic prev_q;

    // Next previous-value is simply the current input.
    always_comb begin
        prev_d = sig;
    end

    // Register the previous value of the input.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/score_logger.sv
// score_logger: accumulates the running score, writes each final score into a
// circular slot of the score memory on game over, and zeroes the whole memory
// after reset. Optional macro SCORE_LOGGER_SKIP_ZERO_EN suppresses logging of
// games that end with a score of zero.
module score_logger
    import score_log_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                point,
    input  logic                game_over,
    score_logger_if.master      mem,
    output logic [SCORE_W-1:0]  score,
    output logic [ADDR_W:0]     entries,
    output logic                busy
);

    logic go_rise;

    rising_edge_detect u_go_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .sig     (game_over),
        .rise    (go_rise)
    );

    log_state_t         state_d,    state_q;
    logic [ADDR_W-1:0]  clr_addr_d, clr_addr_q;
    logic [ADDR_W-1:0]  wr_ptr_d,   wr_ptr_q;
    logic [ADDR_W:0]    entries_d,  entries_q;
    logic [SCORE_W-1:0] score_d,    score_q;
    logic               pending_d,  pending_q;
    logic               wren_d,     wren_q;
    logic [ADDR_W-1:0]  address_d,  address_q;
    logic [SCORE_W-1:0] data_d,     data_q;
    logic               busy_d,     busy_q;
    logic [SCORE_W-1:0] score_next;
    logic               do_write;

    // Next-state and next-output logic; the write strobe is prepared on the
    // PLAY->WRITE transition so wren is visible right after the game-over edge.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ptr_d   = wr_ptr_q;
        entries_d  = entries_q;
        score_d    = score_q;
        pending_d  = pending_q;
        wren_d     = 1'b0;
        address_d  = address_q;
        data_d     = data_q;
        busy_d     = busy_q;
        score_next = point ? sat_inc(score_q) : score_q;
        do_write   = 1'b1;

        case (state_q)
            CLEAR: begin
                wren_d     = 1'b1;
                address_d  = clr_addr_q;
                data_d     = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (go_rise) begin
                    pending_d = 1'b1;
                end
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = PLAY;
                    busy_d  = 1'b0;
                end
            end
            PLAY: begin
                score_d = score_next;
                if (go_rise || pending_q) begin
`ifdef SCORE_LOGGER_SKIP_ZERO_EN
                    do_write = (score_next != '0);
`endif
                    if (do_write) begin
                        state_d   = WRITE;
                        wren_d    = 1'b1;
                        address_d = wr_ptr_q;
                        data_d    = score_next;
                    end else begin
                        state_d   = HOLD;
                        pending_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                entries_d = (entries_q == (ADDR_W + 1)'(DEPTH)) ? entries_q
                                                                  : entries_q + 1'b1;
                pending_d = 1'b0;
                state_d   = HOLD;
            end
            HOLD: begin
                if (!game_over) begin
                    score_d = '0;
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // State and registered outputs; reset restarts the sweep and drops the log.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            wr_ptr_q   <= '0;
            entries_q  <= '0;
            score_q    <= '0;
            pending_q  <= 1'b0;
            wren_q     <= 1'b0;
            address_q  <= '0;
            data_q     <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            entries_q  <= entries_d;
            score_q    <= score_d;
            pending_q  <= pending_d;
            wren_q     <= wren_d;
            address_q  <= address_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign mem.wren    = wren_q;
    assign mem.address = address_q;
    assign mem.data    = data_q;
    assign score       = score_q;
    assign entries     = entries_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_score_logger.sv
// Self-checking bench for score_logger: randomized point streams checked
// against a slot/pointer/count model of the score log.
module tb_score_logger;

`ifdef SCORE_LOGGER_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       point;
    logic       game_over;
    logic [9:0] score;
    logic [5:0] entries;
    logic       busy;

    score_logger_if mem_if ();

    score_logger dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .point     (point),
        .game_over (game_over),
        .mem       (mem_if),
        .score     (score),
        .entries   (entries),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference log state: next slot and number of games logged.
    int exp_ptr     = 0;
    int exp_entries = 0;

    function automatic int sat(input int v);
        return (v > 999) ? 999 : v;
    endfunction

    function automatic void log_write();
        exp_ptr     = (exp_ptr + 1) % 32;
        exp_entries = (exp_entries >= 32) ? 32 : exp_entries + 1;
    endfunction

    task automatic do_reset(input bit go_level);
        @(negedge clock);
        reset_n = 1'b0; point = 1'b0; game_over = go_level;
        repeat (2) @(negedge clock);
        total++;
        if (mem_if.wren !== 1'b0 || busy !== 1'b1 || score !== 10'd0 || entries !== 6'd0 ||
            mem_if.address !== 5'd0 || mem_if.data !== 10'd0) begin
            bad++;
            $display("FAIL reset_state: wren=%0b busy=%0b score=%0d entries=%0d addr=%0d data=%0d required 0/1/0/0/0/0",
                     mem_if.wren, busy, score, entries, mem_if.address, mem_if.data);
        end
        exp_ptr = 0; exp_entries = 0;
        reset_n = 1'b1;
    endtask

    // Walk the 32-cycle clear sweep; go_at >= 0 raises game_over mid-sweep.
    task automatic check_sweep(input int go_at);
        int busy_cnt;
        bit exp_wr;
        busy_cnt = 1;  // the release cycle itself, busy already checked high
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            total++;
            if (mem_if.wren !== 1'b1 || mem_if.address !== 5'(k) || mem_if.data !== 10'd0) begin
                bad++;
                $display("FAIL sweep_write[%0d]: wren=%0b addr=%0d data=%0d required wren=1 addr=%0d data=0",
                         k, mem_if.wren, mem_if.address, mem_if.data, k);
            end
            if (busy === 1'b1) busy_cnt++;
            if (k == go_at) game_over = 1'b1;
        end
        @(negedge clock);
        total++;
        if (busy_cnt != 32 || busy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_busy: high_cycles=%0d busy_now=%0b required 32 and 0", busy_cnt, busy);
        end
        exp_wr = (go_at >= 0) && !SKIP;
        total++;
        if (exp_wr) begin
            if (mem_if.wren !== 1'b1 || mem_if.address !== 5'd0 || mem_if.data !== 10'd0) begin
                bad++;
                $display("FAIL pending_write: wren=%0b addr=%0d data=%0d required wren=1 addr=0 data=0",
                         mem_if.wren, mem_if.address, mem_if.data);
            end
            log_write();
        end else if (mem_if.wren !== 1'b0) begin
            bad++;
            $display("FAIL post_sweep_idle: wren=%0b required 0", mem_if.wren);
        end
        repeat (2) @(negedge clock);
        total++;
        if (mem_if.wren !== 1'b0 || entries !== 6'(exp_entries)) begin
            bad++;
            $display("FAIL post_sweep_entries: wren=%0b entries=%0d required wren=0 entries=%0d",
                     mem_if.wren, entries, exp_entries);
        end
        game_over = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (score !== 10'd0 || mem_if.wren !== 1'b0) begin
            bad++;
            $display("FAIL post_sweep_score: score=%0d wren=%0b required 0 and 0", score, mem_if.wren);
        end
    endtask

    // One game: random-density point stream totalling 'tot' pulses, the last
    // one optionally coincident with the game_over rise.
    task automatic run_game(input int tot, input bit coinc);
        int applied;
        int pre;
        int exp_s;
        bit p;
        bit exp_wr;
        applied = 0;
        pre = tot - coinc;
        while (applied < pre) begin
            @(negedge clock);
            total++;
            if (score !== 10'(sat(applied))) begin
                bad++;
                $display("FAIL live_score: score=%0d required %0d", score, sat(applied));
            end
            p = ($urandom_range(0, 3) != 0);
            point = p;
            if (p) applied++;
        end
        @(negedge clock);
        total++;
        if (score !== 10'(sat(applied))) begin
            bad++;
            $display("FAIL live_score_end: score=%0d required %0d", score, sat(applied));
        end
        point = coinc; game_over = 1'b1;
        applied += coinc;
        exp_s  = sat(applied);
        exp_wr = !(SKIP && exp_s == 0);
        @(negedge clock);
        point = 1'b0;
        total++;
        if (exp_wr) begin
            if (mem_if.wren !== 1'b1 || mem_if.address !== 5'(exp_ptr) || mem_if.data !== 10'(exp_s)) begin
                bad++;
                $display("FAIL game_write: wren=%0b addr=%0d data=%0d required wren=1 addr=%0d data=%0d",
                         mem_if.wren, mem_if.address, mem_if.data, exp_ptr, exp_s);
            end
            log_write();
        end else if (mem_if.wren !== 1'b0) begin
            bad++;
            $display("FAIL zero_skip: wren=%0b required 0", mem_if.wren);
        end
        @(negedge clock);
        total++;
        if (mem_if.wren !== 1'b0 || entries !== 6'(exp_entries) || score !== 10'(exp_s)) begin
            bad++;
            $display("FAIL game_hold: wren=%0b entries=%0d score=%0d required wren=0 entries=%0d score=%0d",
                     mem_if.wren, entries, score, exp_entries, exp_s);
        end
        point = 1'($urandom_range(0, 1));
        game_over = 1'b0;
        @(negedge clock);
        point = 1'b0;
        total++;
        if (score !== 10'd0 || mem_if.wren !== 1'b0) begin
            bad++;
            $display("FAIL score_clear: score=%0d wren=%0b required 0 and 0", score, mem_if.wren);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        check_sweep(-1);
    endtask

    task automatic test_single_game();
        run_game(7, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 33; i++) run_game(i, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_saturate();
        run_game(1005, 1'b0);
    endtask

    task automatic test_go_during_sweep();
        do_reset(1'b0);
        check_sweep(10);
    endtask

    task automatic test_go_held_reset();
        do_reset(1'b1);
        check_sweep(-1);
        run_game(0, 1'b0);
    endtask

    task automatic test_random_games();
        for (int i = 0; i < 10; i++) begin
            int s;
            s = $urandom_range(0, 40);
            run_game(s, (s > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0; point = 1'b0; game_over = 1'b0;
        test_reset();
        test_single_game();
        test_wrap();
        test_saturate();
        test_go_during_sweep();
        test_go_held_reset();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
